// File: rtl/tri_area_pkg.sv
// tri_area_pkg
// Shared definitions for the triangle-area scheduler: the controller state
// enum, default operand/result widths and the number of requesters.
// Ports: none (package).
package tri_area_pkg;

  // Controller states: wait for a request, iterate the multiply, hold the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } tas_state_e;

  localparam int DEF_OP_W = 5;   // operand width
  localparam int DEF_Q_W  = 10;  // area quotient width (2*OP_W)
  localparam int DEF_R_W  = 2;   // area remainder width
  localparam int NUM_REQ  = 2;   // requesters sharing the engine

endpackage

// File: rtl/tri_area_rr_arb.sv
// tri_area_rr_arb
// Two-input round-robin arbiter. The requester that did not win the most
// recent accept has priority when both request. After reset requester 0 wins.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request lines
//   accept     : the granted request was taken this cycle
//   grant[1:0] : one-hot grant (all zero when nobody requests)
module tri_area_rr_arb
  import tri_area_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  // Index of the requester that won the last accept
  logic last_q;
  logic last_d;

  // Grant the single requester directly; on contention favour the one that
  // did not win last time. The pointer only moves when a grant is accepted,
  // so a requester dropping valid early just causes re-evaluation.
  always_comb begin
    grant  = req;
    last_d = last_q;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (accept) begin
      last_d = grant[1];
    end
  end

  // Reset to "requester 1 won last" so requester 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tri_area_sched.sv
// tri_area_sched
// Shares one iterative shift-add triangle-area engine between two requesters.
// Computes floor(num1*num2/2) and (num1*num2) mod 2 over OP_W MUL cycles.
// Optional feature macro: TRI_AREA_ZSKIP_EN -- a zero operand skips the
// multiply and goes straight to DONE with a zero result.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   reqX_valid/reqX_num1/reqX_num2 : requester X operands (X = 0, 1)
//   reqX_ready                     : requester X accepted when valid & ready
//   rsp_valid/rsp_ready            : result handshake
//   rsp_id                         : requester owning the result
//   rsp_qarea, rsp_rarea           : area quotient and remainder
module tri_area_sched
  import tri_area_pkg::*;
#(
  parameter int OP_W = DEF_OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [OP_W-1:0]     req0_num1,
  input  logic [OP_W-1:0]     req0_num2,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [OP_W-1:0]     req1_num1,
  input  logic [OP_W-1:0]     req1_num2,
  output logic                req1_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*OP_W-1:0]   rsp_qarea,
  output logic [DEF_R_W-1:0]  rsp_rarea
);

  localparam int Q_W   = 2 * OP_W;
  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  tas_state_e          state_q, state_d;
  logic [OP_W-1:0]     num1_q, num1_d;
  logic [OP_W-1:0]     num2_q, num2_d;
  logic                id_q, id_d;
  logic [Q_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [Q_W-1:0]      rsp_qarea_q, rsp_qarea_d;
  logic [DEF_R_W-1:0]  rsp_rarea_q, rsp_rarea_d;

  logic [NUM_REQ-1:0]  grant;
  logic                in_idle;
  logic                accept;
  logic [OP_W-1:0]     sel_num1;
  logic [OP_W-1:0]     sel_num2;
  logic [Q_W-1:0]      acc_next;

  tri_area_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Ready is only offered in IDLE, and is forced low while reset is held
  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = rst_n & in_idle & grant[0];
  assign req1_ready = rst_n & in_idle & grant[1];
  assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign sel_num1   = grant[1] ? req1_num1 : req0_num1;
  assign sel_num2   = grant[1] ? req1_num2 : req0_num2;

  // One shift-add step: add num2<<cnt when bit cnt of num1 is set
  assign acc_next = num1_q[cnt_q] ? (acc_q + (Q_W'(num2_q) << cnt_q)) : acc_q;

  // Next-state logic for the controller, the datapath and the result registers.
  // The result is loaded on the final MUL step so the outputs are registered.
  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    id_d        = id_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_qarea_d = rsp_qarea_q;
    rsp_rarea_d = rsp_rarea_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          num1_d  = sel_num1;
          num2_d  = sel_num2;
          id_d    = grant[1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
`ifdef TRI_AREA_ZSKIP_EN
          if ((sel_num1 == '0) || (sel_num2 == '0)) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant[1];
            rsp_qarea_d = '0;
            rsp_rarea_d = '0;
          end
`else
          state_d = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_qarea_d = acc_next >> 1;
          rsp_rarea_d = {1'b0, acc_next[0]};
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All controller and datapath state; reset discards any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num1_q      <= '0;
      num2_q      <= '0;
      id_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_qarea_q <= '0;
      rsp_rarea_q <= '0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      id_q        <= id_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_qarea_q <= rsp_qarea_d;
      rsp_rarea_q <= rsp_rarea_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_qarea = rsp_qarea_q;
  assign rsp_rarea = rsp_rarea_q;

endmodule

// File: tb/tb_tri_area_sched.sv
// tb_tri_area_sched
// Self-checking bench for tri_area_sched. Expected results come from plain
// arithmetic (product / 2, product % 2) and a round-robin winner model.
// Honours TRI_AREA_ZSKIP_EN for the zero-operand latency.
module tb_tri_area_sched;
  import tri_area_pkg::*;

  localparam int OP_W = DEF_OP_W;
  localparam int Q_W  = 2 * OP_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [OP_W-1:0]   req0_num1, req0_num2, req1_num1, req1_num2;
  logic              req0_ready, req1_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [Q_W-1:0]    rsp_qarea;
  logic [1:0]        rsp_rarea;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int modelLast  = 1;

  tri_area_sched #(.OP_W(OP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_num1  (req0_num1),
    .req0_num2  (req0_num2),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_num1  (req1_num1),
    .req1_num2  (req1_num2),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_qarea  (rsp_qarea),
    .rsp_rarea  (rsp_rarea)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against the expected one
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive both requester ports
  task automatic applyStimulus(input logic v0, input int a0, input int b0,
                               input logic v1, input int a1, input int b1);
    req0_valid = v0;
    req0_num1  = OP_W'(a0);
    req0_num2  = OP_W'(b0);
    req1_valid = v1;
    req1_num1  = OP_W'(a1);
    req1_num2  = OP_W'(b1);
  endtask

  // Edges between the accept edge and the first cycle with rsp_valid high
  function automatic int expLatency(input int a, input int b);
`ifdef TRI_AREA_ZSKIP_EN
    if (a == 0 || b == 0) return 0;
`endif
    return OP_W;
  endfunction

  // One full transaction, entered and left at a falling edge with the DUT idle
  task automatic runRequest(input string tag,
                            input logic v0, input int a0, input int b0,
                            input logic v1, input int a1, input int b1,
                            input int stall, input logic hold,
                            output int acceptCyc);
    int win, wa, wb, prod, n;
    applyStimulus(v0, a0, b0, v1, a1, b1);
    rsp_ready = (stall == 0);
    win = (v0 && v1) ? (1 - modelLast) : (v0 ? 0 : 1);
    wa  = win ? a1 : a0;
    wb  = win ? b1 : b0;
    prod = wa * wb;
    #1;
    checkOutput({tag, "_rdy0"}, req0_ready, (win == 0));
    checkOutput({tag, "_rdy1"}, req1_ready, (win == 1));
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    modelLast = win;
    if (!hold) applyStimulus(0, 0, 0, 0, 0, 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, n, expLatency(wa, wb));
    checkOutput({tag, "_id"}, rsp_id, win);
    checkOutput({tag, "_qarea"}, rsp_qarea, prod / 2);
    checkOutput({tag, "_rarea"}, rsp_rarea, prod % 2);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_bp_valid"}, rsp_valid, 1);
      checkOutput({tag, "_bp_qarea"}, rsp_qarea, prod / 2);
      checkOutput({tag, "_bp_id"}, rsp_id, win);
      checkOutput({tag, "_bp_rdy"}, {req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_released"}, rsp_valid, 0);
    if (!hold) rsp_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int acc0, acc1, dummy;
    int v0, v1, a0, b0, a1, b1, stall;

    // Reset state, with requests pending to show ready is gated by reset
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1, 7, 5, 1, 3, 3);
    #2;
    checkOutput("rst_valid", rsp_valid, 0);
    checkOutput("rst_id", rsp_id, 0);
    checkOutput("rst_qarea", rsp_qarea, 0);
    checkOutput("rst_rarea", rsp_rarea, 0);
    checkOutput("rst_rdy", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Directed cases
    runRequest("single", 1, 7, 5, 0, 0, 0, 0, 0, dummy);
    runRequest("maxop", 0, 0, 0, 1, 31, 31, 0, 0, dummy);

    // Contention with both valid continuously and rsp_ready tied high
    runRequest("cont0", 1, 6, 4, 1, 3, 3, 0, 1, acc0);
    runRequest("cont1", 1, 6, 4, 1, 3, 3, 0, 1, acc1);
    checkOutput("cont_spacing01", acc1 - acc0, 7);
    runRequest("cont2", 1, 6, 4, 1, 3, 3, 0, 1, acc0);
    checkOutput("cont_spacing12", acc0 - acc1, 7);
    runRequest("cont3", 1, 6, 4, 1, 3, 3, 0, 1, acc1);
    checkOutput("cont_spacing23", acc1 - acc0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b0;

    // Back-pressure for 4 cycles
    runRequest("bp", 1, 10, 13, 0, 0, 0, 4, 0, dummy);

    // Reset during the 3rd MUL cycle of a requester-0 transaction
    applyStimulus(1, 3, 5, 0, 0, 0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("midrst_rdy0", req0_ready, 1);
    @(posedge clk);
    #1;
    modelLast = 0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1, 9, 2, 1, 4, 4);
    #1;
    checkOutput("midrst_valid", rsp_valid, 0);
    checkOutput("midrst_qarea", rsp_qarea, 0);
    checkOutput("midrst_rarea", rsp_rarea, 0);
    checkOutput("midrst_id", rsp_id, 0);
    checkOutput("midrst_rdy", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelLast = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("midrst_noresp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;
    runRequest("rerequest", 1, 9, 2, 1, 4, 4, 0, 0, dummy);

    // Zero operand
    runRequest("zero", 1, 0, 9, 0, 0, 0, 0, 0, dummy);

    // Randomized traffic against the reference model
    for (int k = 0; k < 24; k++) begin
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      if (v0 == 0 && v1 == 0) v0 = 1;
      a0 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 31);
      b0 = $urandom_range(0, 31);
      a1 = $urandom_range(0, 31);
      b1 = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 31);
      stall = $urandom_range(0, 2);
      runRequest("rand", v0[0], a0, b0, v1[0], a1, b1, stall, 0, dummy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tri_area_sched.md
# tri_area_sched

Sequential controller that shares one triangle-area engine between two calculator requesters. It computes floor(num1*num2/2) and the remainder (num1*num2) mod 2. The multiply is done as an iterative shift-add over OP_W cycles instead of a combinational array. The block sits between the calculator's operand front-ends and the result mux, and uses a valid/ready handshake on both sides.

## Interface
- OP_W, default 5: operand width. The area quotient is 2*OP_W bits and the multiply takes OP_W cycles.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  a requester has operands pending.
- req0_num1, req0_num2, req1_num1, req1_num2  in  OP_W  unsigned operands.
- req0_ready, req1_ready  out  1  a request is accepted when valid and ready are both high.
- rsp_valid  out  1  a result is available.
- rsp_ready  in  1  the consumer accepts the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_qarea  out  2*OP_W  floor(num1*num2/2).
- rsp_rarea  out  2  {1'b0, product[0]}.

## Operation
- States:
  - IDLE: waits for a request.
  - MUL: runs the shift-add multiply.
  - DONE: holds the result.
- IDLE:
  - Round-robin grant between the asserted reqX_valid lines. The requester that did not win the last accept has priority.
  - req_ready is high only for the granted requester, and only in IDLE.
  - On accept: latch num1, num2 and the id; clear the accumulator; set the bit counter to 0; update the last-grant pointer; go to MUL.
- MUL:
  - Each cycle, if num1[cnt] is set, add num2<<cnt to the 2*OP_W-bit accumulator, then increment cnt.
  - After the cycle with cnt=OP_W-1, go to DONE.
  - Accumulator arithmetic is unsigned and cannot overflow (31*31=961 fits in 10 bits).
- DONE:
  - rsp_valid=1.
  - rsp_qarea = acc>>1 and rsp_rarea = {0, acc[0]}, both registered.
  - Outputs stay stable until rsp_ready=1. On rsp_ready go to IDLE.
- Both reqX_valid are ignored outside IDLE. Requesters hold their operands until they are accepted.
- A requester that drops valid before it is accepted is not an error; the arbiter simply re-evaluates.

## Timing
- Reset values:
  - state=IDLE; last grant = requester 1, so requester 0 wins first.
  - rsp_valid=0, rsp_id=0, rsp_qarea=0, rsp_rarea=0.
  - req0_ready=0 and req1_ready=0 while rst_n is low. After reset they follow the IDLE grant logic.
- Latency: accept at edge E, MUL occupies edges E+1..E+OP_W, and rsp_valid is high in the cycle after edge E+OP_W. With OP_W=5 this is 6 cycles from accept to rsp_valid.
- Throughput: the rsp_ready edge returns the block to IDLE. The next accept happens at the earliest one edge later, so 1 request per 7 cycles with OP_W=5.
- Back-pressure: rsp_ready low stalls in DONE indefinitely. The result is held, and both req_ready stay 0.
- Reset asserted in any state: immediate return to the reset values. An in-flight result is discarded and no response is produced for it.

## Configuration
- TRI_AREA_ZSKIP_EN defined:
  - In IDLE, if the granted num1==0 or num2==0, the accept edge goes straight to DONE with acc=0.
  - rsp_valid follows 1 cycle after accept, with qarea=0 and rarea=0.
- TRI_AREA_ZSKIP_EN undefined: zero operands take the full OP_W MUL cycles and give the same result.

## Structure
- tri_area_pkg holds:
  - the state enum (IDLE, MUL, DONE);
  - default widths OP_W=5, Q_W=10, R_W=2;
  - the requester count constant (2).
- One sub-module, tri_area_rr_arb:
  - 2-input round-robin arbiter with a last-grant register;
  - ports: clk, rst_n, req[1:0], accept, grant[1:0].
- The FSM, counter and accumulator live in tri_area_sched.

## Test plan
- Single request:
  - Stimulus: req0 with num1=7, num2=5.
  - Required: rsp_qarea=17, rsp_rarea=1, rsp_id=0, rsp_valid exactly 6 cycles after accept.
- Maximum operands:
  - Stimulus: req1 with num1=31, num2=31.
  - Required: rsp_qarea=480, rsp_rarea=1, rsp_id=1.
- Contention:
  - Stimulus: req0 and req1 both valid continuously; req0 has 6,4 and req1 has 3,3; rsp_ready tied to 1.
  - Required: rsp_id sequence 0,1,0,1, results 12/0 and 4/1 alternating, 7-cycle spacing.
- Back-pressure:
  - Stimulus: rsp_ready held low for 4 cycles in DONE.
  - Required: result and rsp_id stable, req0_ready=0 and req1_ready=0 throughout, return to IDLE on the rsp_ready edge.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during the 3rd MUL cycle.
  - Required: rsp_valid=0 and outputs 0 at once, no response for that request, requester 0 wins first on re-request, and a following 9*2 request returns 9/0.
- Zero operand:
  - Stimulus: num1=0, num2=9.
  - Required with TRI_AREA_ZSKIP_EN: rsp_valid 1 cycle after accept, result 0/0.
  - Required without it: 6 cycles, result 0/0.
